// File: rtl/branch_predictor_gshare_if.sv
// Branch-outcome type and the decode/execute <-> gshare predictor interface.
// The master drives requests and feedback; the slave is the predictor.
package bp_pkg;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
endpackage

interface branch_predictor_gshare_if
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = 8,
  parameter int GHR_WIDTH   = 8
);
  logic                   o_ready;
  logic                   i_req_valid;
  logic [31:0]            i_req_pc;
  BranchOutcome           o_req_prediction;
  logic [INDEX_WIDTH-1:0] o_req_index;
  logic [GHR_WIDTH-1:0]   o_req_ghr;
  logic                   i_fb_valid;
  logic [INDEX_WIDTH-1:0] i_fb_index;
  logic [GHR_WIDTH-1:0]   i_fb_ghr;
  BranchOutcome           i_fb_prediction;
  BranchOutcome           i_fb_outcome;

  modport master (
    input  o_ready, o_req_prediction, o_req_index, o_req_ghr,
    output i_req_valid, i_req_pc, i_fb_valid, i_fb_index, i_fb_ghr,
           i_fb_prediction, i_fb_outcome
  );

  modport slave (
    output o_ready, o_req_prediction, o_req_index, o_req_ghr,
    input  i_req_valid, i_req_pc, i_fb_valid, i_fb_index, i_fb_ghr,
           i_fb_prediction, i_fb_outcome
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor: PC xor global history indexes a table of 2-bit
// saturating counters; history is shifted speculatively and repaired on mispredict.
module branch_predictor_gshare
  import bp_pkg::*;
#(
  parameter int INDEX_WIDTH = 8,
  parameter int GHR_WIDTH   = 8
) (
  input  logic clk,
  input  logic rst,
  branch_predictor_gshare_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state;
  logic                   ready_q;
  logic [INDEX_WIDTH-1:0] sweep;
  logic [GHR_WIDTH-1:0]   ghr;
  logic [1:0]             pht [ENTRIES];

  logic [INDEX_WIDTH-1:0] ghr_ext;
  logic [INDEX_WIDTH-1:0] idx;
  BranchOutcome           pred;
  logic                   mispredict;
  logic [1:0]             fb_ctr;
  logic [1:0]             fb_ctr_nxt;
  logic                   unused_bits;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_WIDTH-1:0] = ghr;
  end

  assign idx        = bp.i_req_pc[INDEX_WIDTH+1:2] ^ ghr_ext;
  assign pred       = (ready_q && pht[idx][1]) ? TAKEN : NOT_TAKEN;
  assign mispredict = bp.i_fb_valid && (bp.i_fb_prediction != bp.i_fb_outcome);

  assign bp.o_ready          = ready_q;
  assign bp.o_req_prediction = pred;
  assign bp.o_req_index      = idx;
  assign bp.o_req_ghr        = ready_q ? ghr : '0;

  assign unused_bits = ^{bp.i_req_pc[31:INDEX_WIDTH+2], bp.i_req_pc[1:0],
                         bp.i_fb_ghr[GHR_WIDTH-1]};

  always_comb begin
    fb_ctr     = pht[bp.i_fb_index];
    fb_ctr_nxt = fb_ctr;
    if (bp.i_fb_outcome == TAKEN) begin
      if (fb_ctr != 2'b11) fb_ctr_nxt = fb_ctr + 2'b01;
    end else begin
      if (fb_ctr != 2'b00) fb_ctr_nxt = fb_ctr - 2'b01;
    end
  end

  // Mispredict restore outranks the speculative shift: a same-cycle request is wrong-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= INIT;
      ready_q <= 1'b0;
      sweep   <= '0;
      ghr     <= '0;
    end else begin
      case (state)
        INIT: begin
          sweep <= sweep + 1'b1;
          if (sweep == '1) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (mispredict)
            ghr <= {bp.i_fb_ghr[GHR_WIDTH-2:0], bp.i_fb_outcome};
          else if (bp.i_req_valid)
            ghr <= {ghr[GHR_WIDTH-2:0], pred};
        end
        default: state <= INIT;
      endcase
    end
  end

  // Table has no reset so it maps to RAM; the init sweep clears it instead.
  always_ff @(posedge clk) begin
    if (state == INIT)
      pht[sweep] <= 2'b01;
    else if (bp.i_fb_valid)
      pht[bp.i_fb_index] <= fb_ctr_nxt;
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for the gshare predictor: init sweep, training, speculative
// history, mispredict repair, read-before-write and async reset.
module tb_branch_predictor_gshare;
  import bp_pkg::*;

  logic clk;
  logic rst;
  int   errs;
  int   checks;

  branch_predictor_gshare_if #(.INDEX_WIDTH(8), .GHR_WIDTH(8)) bp ();

  branch_predictor_gshare #(.INDEX_WIDTH(8), .GHR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bp.i_req_valid     = 1'b0;
    bp.i_req_pc        = '0;
    bp.i_fb_valid      = 1'b0;
    bp.i_fb_index      = '0;
    bp.i_fb_ghr        = '0;
    bp.i_fb_prediction = NOT_TAKEN;
    bp.i_fb_outcome    = NOT_TAKEN;
  endtask

  task automatic req(input logic [31:0] pc);
    bp.i_req_valid = 1'b1;
    bp.i_req_pc    = pc;
  endtask

  task automatic fb(input logic [7:0] index, input logic [7:0] snap,
                    input BranchOutcome p, input BranchOutcome o);
    bp.i_fb_valid      = 1'b1;
    bp.i_fb_index      = index;
    bp.i_fb_ghr        = snap;
    bp.i_fb_prediction = p;
    bp.i_fb_outcome    = o;
  endtask

  // Counts edges until o_ready; optionally probes a request mid-sweep.
  task automatic wait_ready(input bit probe, output int n);
    n = 0;
    while (!bp.o_ready && n < 400) begin
      if (probe && n == 10) begin
        req(32'h0000_0400);
        #1;
        chk("init_pred", 32'(bp.o_req_prediction), 32'(NOT_TAKEN));
        chk("init_ghr_out", 32'(bp.o_req_ghr), 32'h0);
      end
      step();
      n++;
      if (probe && n == 11) begin
        idle();
        chk("init_ghr_hold", 32'(bp.o_req_ghr), 32'h0);
      end
    end
  endtask

  int n;

  initial begin
    errs   = 0;
    checks = 0;
    idle();
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bp.o_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_held", 32'(bp.o_ready), 32'h0);
    chk("rst_ghr", 32'(bp.o_req_ghr), 32'h0);
    chk("rst_pred", 32'(bp.o_req_prediction), 32'(NOT_TAKEN));
    rst = 1'b0;
    wait_ready(1'b1, n);
    chk("init_edges", 32'(n), 32'd256);
    chk("ready_ghr", 32'(bp.o_req_ghr), 32'h0);

    // Train 0x10 up to saturation with correctly predicted TAKEN feedback.
    for (int i = 0; i < 3; i++) begin
      fb(8'h10, 8'h00, TAKEN, TAKEN);
      step();
      chk("train_ghr", 32'(bp.o_req_ghr), 32'h0);
    end
    idle();
    req(32'h0000_0040);
    #1;
    chk("train_idx", 32'(bp.o_req_index), 32'h10);
    chk("train_pred", 32'(bp.o_req_prediction), 32'(TAKEN));
    step();
    idle();
    chk("train_shift", 32'(bp.o_req_ghr), 32'h01);

    // Mispredict with zero snapshot puts history back to 0.
    fb(8'h30, 8'h00, TAKEN, NOT_TAKEN);
    step();
    idle();
    chk("restore_zero", 32'(bp.o_req_ghr), 32'h00);

    // Speculative history: T, NT, T.
    req(32'h0000_0040);
    #1;
    chk("spec0_ghr", 32'(bp.o_req_ghr), 32'h00);
    chk("spec0_pred", 32'(bp.o_req_prediction), 32'(TAKEN));
    step();
    req(32'h0000_0000);
    #1;
    chk("spec1_ghr", 32'(bp.o_req_ghr), 32'h01);
    chk("spec1_pred", 32'(bp.o_req_prediction), 32'(NOT_TAKEN));
    step();
    req(32'h0000_0048);
    #1;
    chk("spec2_ghr", 32'(bp.o_req_ghr), 32'h02);
    chk("spec2_idx", 32'(bp.o_req_index), 32'h10);
    chk("spec2_pred", 32'(bp.o_req_prediction), 32'(TAKEN));
    step();
    idle();
    chk("spec_final", 32'(bp.o_req_ghr), 32'h05);

    // Invalid feedback must do nothing.
    fb(8'h10, 8'h40, TAKEN, NOT_TAKEN);
    bp.i_fb_valid = 1'b0;
    step();
    idle();
    chk("fb_invalid", 32'(bp.o_req_ghr), 32'h05);

    // Mispredict restore beats same-cycle request.
    fb(8'h30, 8'h40, TAKEN, NOT_TAKEN);
    req(32'h0000_0040);
    #1;
    chk("mis_req_pred", 32'(bp.o_req_prediction), 32'(NOT_TAKEN));
    step();
    idle();
    chk("mis_restore", 32'(bp.o_req_ghr), 32'h80);

    // Walk 0x10 back down 11 -> 10 -> 01.
    repeat (2) begin
      fb(8'h10, 8'h00, NOT_TAKEN, NOT_TAKEN);
      step();
    end
    idle();
    chk("dec_ghr", 32'(bp.o_req_ghr), 32'h80);

    // Read-before-write on index 0x10 (counter 01).
    req(32'h0000_0240);
    fb(8'h10, 8'h00, TAKEN, TAKEN);
    #1;
    chk("rbw_idx", 32'(bp.o_req_index), 32'h10);
    chk("rbw_pred", 32'(bp.o_req_prediction), 32'(NOT_TAKEN));
    step();
    idle();
    chk("rbw_ghr", 32'(bp.o_req_ghr), 32'h00);
    req(32'h0000_0040);
    fb(8'h10, 8'h00, TAKEN, TAKEN);
    #1;
    chk("rbw_next_idx", 32'(bp.o_req_index), 32'h10);
    chk("rbw_next_pred", 32'(bp.o_req_prediction), 32'(TAKEN));
    step();
    idle();
    bp.i_req_pc = 32'h0000_0044;
    #1;
    chk("pre_rst_ghr", 32'(bp.o_req_ghr), 32'h01);
    chk("pre_rst_pred", 32'(bp.o_req_prediction), 32'(TAKEN));

    // Async reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(bp.o_ready), 32'h0);
    chk("arst_ghr", 32'(bp.o_req_ghr), 32'h0);
    chk("arst_pred", 32'(bp.o_req_prediction), 32'(NOT_TAKEN));
    #2;
    rst = 1'b0;
    wait_ready(1'b0, n);
    chk("reinit_edges", 32'(n), 32'd256);
    req(32'h0000_0040);
    #1;
    chk("reinit_idx", 32'(bp.o_req_index), 32'h10);
    chk("reinit_pred", 32'(bp.o_req_prediction), 32'(NOT_TAKEN));
    step();
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
